btb_assoc_predictor: RTL and testbench
======================================

# btb_assoc_predictor

Parametrised set-associative branch target buffer with per-entry saturating direction counters. It sits between fetch and execute. Fetch receives a same-cycle taken/target prediction for the current PC. Execute writes back resolved branch outcomes that train the counters, allocate new entries and correct stale targets. It is the successor to the direct-mapped BTB. It adds associativity, a configurable counter width, a correct tag split, flush support and optional performance counters.

## Interface
- SETS, 64, number of sets; power of two, ≥2
- WAYS, 2, ways per set; power of two, ≥1
- CTR_WIDTH, 2, direction counter width in bits; ≥1
- PC_WIDTH, 32, PC width in bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- fetchPc  in  PC_WIDTH  PC being fetched
- fetchHit  out  1  predict taken: tag hit and counter MSB set
- fetchTarget  out  PC_WIDTH  predicted target; 0 when fetchHit=0
- exValid  in  1  execute stage holds a resolved branch or jump
- exPc  in  PC_WIDTH  PC of the resolved instruction
- exTaken  in  1  resolved direction
- exTarget  in  PC_WIDTH  resolved target
- flush  in  1  invalidate all entries
- fetchValid  in  1  fetch lookup is real; present only with BTB_PERF_EN
- exMispredict  in  1  execute detected a misprediction; present only with BTB_PERF_EN
- perfLookups, perfHits, perfMispredicts  out  32 each  event counters; present only with BTB_PERF_EN

## Operation
- Index = pc[IDX+1:2] and tag = pc[PC_WIDTH-1:IDX+2], where IDX=log2(SETS). pc[1:0] is ignored.
- Each entry holds valid, tag, target and a counter of CTR_WIDTH bits.
- **Lookup:** compare the tag against all ways of the indexed set.
  - If more than one way matches, the lowest-numbered way wins.
  - fetchHit = match && counter[CTR_WIDTH-1].
- **Update, when exValid=1:**
  - Hit, exTaken=1: counter increments, saturating at all-ones. If the stored target differs from exTarget, the target is overwritten.
  - Hit, exTaken=0: counter decrements, saturating at 0. The entry stays valid.
  - Miss, exTaken=1: allocate. Target = exTarget, counter = 2^(CTR_WIDTH-1) (weakly taken), valid=1.
  - Miss, exTaken=0: no change.
- **Victim selection:** the lowest-numbered invalid way. If the set is full, the way given by the set's round-robin pointer, which then increments modulo WAYS. The pointer advances only on allocation into a full set.
- **flush=1:** all valid bits are cleared at the next edge. Counters, targets and pointers are left unchanged.
- **Flush and update in the same cycle:** flush wins and the update is discarded.
- **Reset:** all valid bits are 0 and all round-robin pointers are 0. This makes fetchHit=0 and fetchTarget=0.

## Timing
- Lookup is purely combinational: fetchPc to fetchHit/fetchTarget in the same cycle.
- An update becomes visible to lookup from the cycle after the exValid edge.
- A fetch and an update to the same entry in the same cycle: the fetch sees the pre-update contents.
- Reset asserted mid-operation clears state immediately, with no clock required. Release is synchronised upstream.
- Perf counters increment on the edge following their qualifying cycle.

## Configuration
- BTB_PERF_EN defined:
  - fetchValid, exMispredict and the three perf outputs exist.
  - perfLookups counts cycles with fetchValid=1.
  - perfHits counts cycles with fetchValid && fetchHit.
  - perfMispredicts counts cycles with exMispredict=1.
  - All counters are 32-bit, wrap at 2^32, reset to 0, and are not cleared by flush.
- BTB_PERF_EN undefined: these ports and the counter logic are absent. Prediction behaviour is identical in both builds.

## Structure
- Shared package bp_pkg holds:
  - the saturating-counter next-state function, parametrised by width;
  - the weakly-taken initial-value constant;
  - the index/tag extraction helper functions.
- The entry struct is declared locally because it depends on module parameters.
- One sub-module, bp_perf_counters, holds the three counters and is instantiated only under BTB_PERF_EN.

## Test plan
All scenarios use defaults SETS=64, WAYS=2, CTR_WIDTH=2.
- Reset, then fetchPc=0x100 → fetchHit=0, fetchTarget=0x0.
- exValid, exTaken=1, exPc=0x100, exTarget=0x200, then fetchPc=0x100 next cycle → fetchHit=1, fetchTarget=0x200. Same cycle as the update → fetchHit=0.
- Counter training on 0x100:
  - two not-taken updates → fetchHit=0 (counter 0);
  - one taken → still 0 (counter 1);
  - another taken → fetchHit=1 (counter 2);
  - taken with exTarget=0x300 → fetchTarget=0x300.
- Taken allocations of 0x100, 0x1100, 0x2100 (all set 0) → 0x2100 replaces 0x100 in way 0. 0x100 misses, 0x1100 and 0x2100 hit, and the set-0 pointer is 1.
- flush=1 in the same cycle as a taken allocation of 0x400 → next cycle 0x100, 0x1100, 0x2100 and 0x400 all give fetchHit=0.
- With BTB_PERF_EN:
  - stimulus: three fetchValid cycles with exactly one hit, then two exMispredict pulses;
  - expected: perfLookups=3, perfHits=1, perfMispredicts=2;
  - an async rst pulse → all three read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor helpers: saturating counter arithmetic, weakly-taken
// initial value and PC index/tag extraction. Counter widths up to CTR_MAX_W bits.
package bp_pkg;

  localparam int unsigned CTR_MAX_W = 16;
  localparam int unsigned PC_MAX_W  = 64;

  typedef logic [CTR_MAX_W-1:0] ctr_t;
  typedef logic [PC_MAX_W-1:0]  pc_t;

  localparam ctr_t CTR_ONE = 16'd1;
  localparam pc_t  PC_ONE  = 64'd1;

  function automatic ctr_t ctr_max(input int unsigned width);
    return (CTR_ONE << width) - CTR_ONE;
  endfunction

  // Weakly taken: only the MSB of a width-bit counter set.
  function automatic ctr_t ctr_weak_taken(input int unsigned width);
    return CTR_ONE << (width - 32'd1);
  endfunction

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic up, input int unsigned width);
    ctr_t res;
    if (up) begin
      res = (ctr == ctr_max(width)) ? ctr : ctr + CTR_ONE;
    end else begin
      res = (ctr == '0) ? ctr : ctr - CTR_ONE;
    end
    return res;
  endfunction

  function automatic pc_t pc_index(input pc_t pc, input int unsigned idx_w);
    return (pc >> 2) & ((PC_ONE << idx_w) - PC_ONE);
  endfunction

  function automatic pc_t pc_tag(input pc_t pc, input int unsigned idx_w);
    return pc >> (idx_w + 32'd2);
  endfunction

endpackage

// File: rtl/bp_perf_counters.sv
// Free-running 32-bit event counters for BTB lookups, predicted-taken hits and
// mispredictions; cleared only by reset.
module bp_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup,
  input  logic        hit,
  input  logic        mispredict,
  output logic [31:0] perfLookups,
  output logic [31:0] perfHits,
  output logic [31:0] perfMispredicts
);

  logic [31:0] lookups_r;
  logic [31:0] hits_r;
  logic [31:0] mispredicts_r;

  // Event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookups_r     <= 32'd0;
      hits_r        <= 32'd0;
      mispredicts_r <= 32'd0;
    end else begin
      if (lookup)     lookups_r     <= lookups_r + 32'd1;
      if (hit)        hits_r        <= hits_r + 32'd1;
      if (mispredict) mispredicts_r <= mispredicts_r + 32'd1;
    end
  end

  assign perfLookups     = lookups_r;
  assign perfHits        = hits_r;
  assign perfMispredicts = mispredicts_r;

endmodule

// File: rtl/btb_assoc_predictor.sv
// Set-associative BTB with saturating direction counters and round-robin replacement.
// Define BTB_PERF_EN to add fetchValid/exMispredict inputs and the perf counter outputs.
module btb_assoc_predictor
  import bp_pkg::*;
#(
  parameter int unsigned SETS      = 64,
  parameter int unsigned WAYS      = 2,
  parameter int unsigned CTR_WIDTH = 2,
  parameter int unsigned PC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] fetchPc,
  output logic                fetchHit,
  output logic [PC_WIDTH-1:0] fetchTarget,
  input  logic                exValid,
  input  logic [PC_WIDTH-1:0] exPc,
  input  logic                exTaken,
  input  logic [PC_WIDTH-1:0] exTarget,
  input  logic                flush
`ifdef BTB_PERF_EN
  ,
  input  logic                fetchValid,
  input  logic                exMispredict,
  output logic [31:0]         perfLookups,
  output logic [31:0]         perfHits,
  output logic [31:0]         perfMispredicts
`endif
);

  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG_W = PC_WIDTH - IDX - 2;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(ctr_weak_taken(CTR_WIDTH));
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);
  localparam logic [WAY_W-1:0] WAY_ONE  = WAY_W'(1);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [PC_WIDTH-1:0]  target;
    logic [CTR_WIDTH-1:0] ctr;
  } entry_t;

  entry_t           tbl_r [SETS][WAYS];
  logic [WAY_W-1:0] rr_r  [SETS];

  logic [IDX-1:0]       f_idx_s, e_idx_s;
  logic [TAG_W-1:0]     f_tag_s, e_tag_s;
  logic [WAYS-1:0]      f_hitv_s, e_hitv_s, e_validv_s;
  logic [WAY_W-1:0]     f_way_s, e_way_s, e_free_s, e_victim_s;
  logic                 e_match_s, e_full_s;
  logic [CTR_WIDTH-1:0] e_ctr_next_s;

  // Tag compare for both ports; descending scans leave the lowest matching/free way.
  always_comb begin
    f_idx_s    = IDX'(pc_index(pc_t'(fetchPc), IDX));
    f_tag_s    = TAG_W'(pc_tag(pc_t'(fetchPc), IDX));
    e_idx_s    = IDX'(pc_index(pc_t'(exPc), IDX));
    e_tag_s    = TAG_W'(pc_tag(pc_t'(exPc), IDX));
    f_hitv_s   = '0;
    e_hitv_s   = '0;
    e_validv_s = '0;
    f_way_s    = '0;
    e_way_s    = '0;
    e_free_s   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      f_hitv_s[w]   = tbl_r[f_idx_s][w].valid && (tbl_r[f_idx_s][w].tag == f_tag_s);
      e_hitv_s[w]   = tbl_r[e_idx_s][w].valid && (tbl_r[e_idx_s][w].tag == e_tag_s);
      e_validv_s[w] = tbl_r[e_idx_s][w].valid;
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      f_way_s  = f_hitv_s[w]    ? WAY_W'(w) : f_way_s;
      e_way_s  = e_hitv_s[w]    ? WAY_W'(w) : e_way_s;
      e_free_s = !e_validv_s[w] ? WAY_W'(w) : e_free_s;
    end
    e_match_s    = |e_hitv_s;
    e_full_s     = &e_validv_s;
    e_victim_s   = e_full_s ? rr_r[e_idx_s] : e_free_s;
    e_ctr_next_s = CTR_WIDTH'(ctr_next(ctr_t'(tbl_r[e_idx_s][e_way_s].ctr), exTaken, CTR_WIDTH));
    fetchHit     = (|f_hitv_s) && tbl_r[f_idx_s][f_way_s].ctr[CTR_WIDTH-1];
    fetchTarget  = fetchHit ? tbl_r[f_idx_s][f_way_s].target : '0;
  end

  // Table and replacement-pointer state; flush overrides any concurrent update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        rr_r[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          tbl_r[s][w] <= '0;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          tbl_r[s][w].valid <= 1'b0;
        end
      end
    end else if (exValid) begin
      if (e_match_s) begin
        tbl_r[e_idx_s][e_way_s].ctr <= e_ctr_next_s;
        if (exTaken && (tbl_r[e_idx_s][e_way_s].target != exTarget)) begin
          tbl_r[e_idx_s][e_way_s].target <= exTarget;
        end
      end else if (exTaken) begin
        tbl_r[e_idx_s][e_victim_s] <= '{valid: 1'b1, tag: e_tag_s, target: exTarget, ctr: CTR_INIT};
        if (e_full_s) begin
          rr_r[e_idx_s] <= (rr_r[e_idx_s] == LAST_WAY) ? '0 : rr_r[e_idx_s] + WAY_ONE;
        end
      end
    end
  end

`ifdef BTB_PERF_EN
  logic perf_hit_s;
  assign perf_hit_s = fetchValid && fetchHit;

  bp_perf_counters u_perf (
    .clk             (clk),
    .rst             (rst),
    .lookup          (fetchValid),
    .hit             (perf_hit_s),
    .mispredict      (exMispredict),
    .perfLookups     (perfLookups),
    .perfHits        (perfHits),
    .perfMispredicts (perfMispredicts)
  );
`endif

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Directed bench for btb_assoc_predictor (default parameters); expected lookups
// go through a scoreboard queue. Perf checks are compiled in with BTB_PERF_EN.
module tb_btb_assoc_predictor;

  logic        clk, rst;
  logic [31:0] fetchPc, fetchTarget, exPc, exTarget;
  logic        fetchHit, exValid, exTaken, flush;
`ifdef BTB_PERF_EN
  logic        fetchValid, exMispredict;
  logic [31:0] perfLookups, perfHits, perfMispredicts;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        hit;
    logic [31:0] tgt;
  } exp_t;
  exp_t sb_q[$];

  btb_assoc_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .fetchPc     (fetchPc),
    .fetchHit    (fetchHit),
    .fetchTarget (fetchTarget),
    .exValid     (exValid),
    .exPc        (exPc),
    .exTaken     (exTaken),
    .exTarget    (exTarget),
    .flush       (flush)
`ifdef BTB_PERF_EN
    ,
    .fetchValid      (fetchValid),
    .exMispredict    (exMispredict),
    .perfLookups     (perfLookups),
    .perfHits        (perfHits),
    .perfMispredicts (perfMispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc,
                              input logic hit, input logic [31:0] tgt);
    exp_t e;
    e.tag = tag;
    e.hit = hit;
    e.tgt = tgt;
    sb_q.push_back(e);
    fetchPc = pc;
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (fetchHit === e.hit && fetchTarget === e.tgt)
      else begin
        errors++;
        $error("FAIL %s: observed hit=%0b target=0x%08h, expected hit=%0b target=0x%08h",
               e.tag, fetchHit, fetchTarget, e.hit, e.tgt);
      end
  endtask

  task automatic ex_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    exValid  = 1'b1;
    exPc     = pc;
    exTaken  = taken;
    exTarget = tgt;
    tick();
    exValid  = 1'b0;
  endtask

`ifdef BTB_PERF_EN
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
  endtask
`endif

  initial begin
    rst      = 1'b0;
    fetchPc  = 32'h0;
    exValid  = 1'b0;
    exPc     = 32'h0;
    exTaken  = 1'b0;
    exTarget = 32'h0;
    flush    = 1'b0;
`ifdef BTB_PERF_EN
    fetchValid   = 1'b0;
    exMispredict = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b1;
    expect_fetch("reset_lookup", 32'h100, 1'b0, 32'h0);

    // First allocation: invisible in its own cycle, visible the next.
    exValid = 1'b1; exPc = 32'h100; exTaken = 1'b1; exTarget = 32'h200;
    expect_fetch("same_cycle_update", 32'h100, 1'b0, 32'h0);
    tick();
    exValid = 1'b0;
    expect_fetch("alloc_visible", 32'h100, 1'b1, 32'h200);

    // Counter training.
    ex_update(32'h100, 1'b0, 32'h0);
    ex_update(32'h100, 1'b0, 32'h0);
    expect_fetch("ctr_zero", 32'h100, 1'b0, 32'h0);
    ex_update(32'h100, 1'b1, 32'h200);
    expect_fetch("ctr_one", 32'h100, 1'b0, 32'h0);
    ex_update(32'h100, 1'b1, 32'h200);
    expect_fetch("ctr_two", 32'h100, 1'b1, 32'h200);
    ex_update(32'h100, 1'b1, 32'h300);
    expect_fetch("target_fix", 32'h100, 1'b1, 32'h300);

    // Replacement in set 0.
    ex_update(32'h100, 1'b1, 32'h300);
    ex_update(32'h1100, 1'b1, 32'h1200);
    ex_update(32'h2100, 1'b1, 32'h2200);
    expect_fetch("evicted_0x100", 32'h100, 1'b0, 32'h0);
    expect_fetch("way1_0x1100", 32'h1100, 1'b1, 32'h1200);
    expect_fetch("way0_0x2100", 32'h2100, 1'b1, 32'h2200);
    ex_update(32'h3100, 1'b1, 32'h3200);
    expect_fetch("rr1_evicts_0x1100", 32'h1100, 1'b0, 32'h0);
    expect_fetch("rr1_new_0x3100", 32'h3100, 1'b1, 32'h3200);
    expect_fetch("rr1_keeps_0x2100", 32'h2100, 1'b1, 32'h2200);
    ex_update(32'h100, 1'b1, 32'h300);
    expect_fetch("rr_wrap_evicts_0x2100", 32'h2100, 1'b0, 32'h0);
    expect_fetch("rr_wrap_new_0x100", 32'h100, 1'b1, 32'h300);
    expect_fetch("rr_wrap_keeps_0x3100", 32'h3100, 1'b1, 32'h3200);

    // Flush beats a concurrent allocation.
    flush = 1'b1;
    ex_update(32'h400, 1'b1, 32'h500);
    flush = 1'b0;
    expect_fetch("flush_0x100", 32'h100, 1'b0, 32'h0);
    expect_fetch("flush_0x1100", 32'h1100, 1'b0, 32'h0);
    expect_fetch("flush_0x2100", 32'h2100, 1'b0, 32'h0);
    expect_fetch("flush_0x400", 32'h400, 1'b0, 32'h0);
    ex_update(32'h400, 1'b1, 32'h500);
    expect_fetch("post_flush_alloc", 32'h400, 1'b1, 32'h500);
    expect_fetch("post_flush_stale", 32'h3100, 1'b0, 32'h0);

    // Set 1 and not-taken behaviour.
    expect_fetch("set1_empty", 32'h104, 1'b0, 32'h0);
    ex_update(32'h204, 1'b0, 32'h900);
    expect_fetch("nt_miss_no_alloc", 32'h204, 1'b0, 32'h0);
    ex_update(32'h104, 1'b1, 32'h800);
    expect_fetch("set1_alloc", 32'h104, 1'b1, 32'h800);
    ex_update(32'h104, 1'b0, 32'h0);
    expect_fetch("set1_weak_nt", 32'h104, 1'b0, 32'h0);
    ex_update(32'h104, 1'b1, 32'h800);
    expect_fetch("set1_still_valid", 32'h104, 1'b1, 32'h800);
    expect_fetch("low_bits_ignored", 32'h106, 1'b1, 32'h800);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b0;
    expect_fetch("async_reset", 32'h104, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    expect_fetch("after_reset", 32'h400, 1'b0, 32'h0);

`ifdef BTB_PERF_EN
    ex_update(32'h104, 1'b1, 32'h800);
    fetchValid = 1'b1;
    fetchPc = 32'h104; tick();
    fetchPc = 32'h108; tick();
    fetchPc = 32'h10C; tick();
    fetchValid = 1'b0;
    exMispredict = 1'b1;
    tick();
    tick();
    exMispredict = 1'b0;
    check32("perf_lookups", perfLookups, 32'd3);
    check32("perf_hits", perfHits, 32'd1);
    check32("perf_mispredicts", perfMispredicts, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check32("perf_lookups_rst", perfLookups, 32'd0);
    check32("perf_hits_rst", perfHits, 32'd0);
    check32("perf_mispredicts_rst", perfMispredicts, 32'd0);
    tick();
    rst = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
